// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is off, static high, or driven by a shared
// 8-bit PWM whose duty is shadowed and only updated at a period boundary.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000,
  parameter int DIV_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_strobe
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [39:0]      sync1;
  logic [39:0]      sync2;
  logic [DIV_W-1:0] presc;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_sh;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [7:0]       duty_s;
  logic             tick;
  logic             wrap;
  logic             level;

  assign en_out = sync2[15:0];
  assign en_pwm = sync2[31:16];
  assign duty_s = sync2[39:32];

  assign tick  = (presc == DIV_LAST);
  assign wrap  = tick && (pwm_cnt == 8'hFF);
  // 0xFF is forced to a solid high so full scale has no low slot
  assign level = (duty_sh == 8'hFF) ? 1'b1 : (pwm_cnt < duty_sh);

  // Control bits are quasi-static, so an independent per-bit synchronizer is safe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                en_reg_out_15_8, en_reg_out_7_0};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc         <= '0;
      pwm_cnt       <= '0;
      duty_sh       <= '0;
      period_strobe <= 1'b0;
    end else begin
      presc         <= tick ? '0 : presc + DIV_W'(1);
      period_strobe <= wrap;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap)
        duty_sh <= duty_s;
    end
  end

  // Output enable wins; PWM enable only selects level versus static high
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out <= '0;
    else
      out <= en_out & (~en_pwm | {16{level}});
  end

endmodule
